// File: rtl/cs_resolve.sv
// cs_resolve: turns a carry-save pair (p, q) into a binary result z.
// The pair is added digit-serially, W bits per cycle.
// With CS_RESOLVE_REDUCE_EN defined, the sum is then reduced by m using
// digit-serial trial subtractions:
//   - up to 3 committing passes;
//   - a 4th pass that only compares and sets ovf.
// Without the macro the raw sum is returned, and ovf flags bits above N.
//
// Handshake contract:
//   - input side:  a transfer happens on a rising edge with in_valid && in_ready.
//   - output side: a transfer happens on a rising edge with out_valid && out_ready.
//   - in_ready is high only in IDLE, so a new operand can never be taken
//     on the same edge that hands a result off.
module cs_resolve #(
   parameter int N = 512,
   parameter int W = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N:0]   p,
   input  logic [N:0]   q,
   input  logic [N-1:0] m,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] z,
   output logic         ovf,
   output logic [1:0]   dbg_state
);

   localparam int C  = N / W;
   localparam int CW = (C > 1) ? $clog2(C) : 1;
   localparam logic [CW-1:0] LAST = CW'(C - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_SUB  = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic [N:0]    p_q, p_d;
   logic [N:0]    q_q, q_d;
   logic [N+1:0]  s_q, s_d;
   logic          ovf_q, ovf_d;

   // Current digit position and the add datapath for that digit.
   int            dig_lo;
   logic [W:0]    add_w;
   logic [1:0]    top_sum;

`ifdef CS_RESOLVE_REDUCE_EN
   logic [N-1:0]  m_q, m_d;
   logic [N-1:0]  d_q, d_d;
   logic          borrow_q, borrow_d;
   logic [1:0]    pass_q, pass_d;

   // Subtract datapath: current digit of s - m, plus the finished pass result.
   logic [W:0]    sub_w;
   logic [N-1:0]  d_full;
   logic [1:0]    top_diff;
   logic          final_borrow;
`else
   // m plays no part when reduction is compiled out.
   logic          unused_m;
   assign unused_m = ^m;
`endif

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_HOLD);
   assign z         = s_q[N-1:0];
   assign ovf       = ovf_q;
   assign dbg_state = state_q;

   // Next-state and datapath logic for the IDLE/ADD/SUB/HOLD sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      p_d     = p_q;
      q_d     = q_q;
      s_d     = s_q;
      ovf_d   = ovf_q;

      dig_lo  = int'(cnt_q) * W;

      // Add the current digit; the two top bits come from the carry out of the last digit.
      add_w   = {1'b0, p_q[dig_lo +: W]} + {1'b0, q_q[dig_lo +: W]} + {{W{1'b0}}, carry_q};
      top_sum = {1'b0, p_q[N]} + {1'b0, q_q[N]} + {1'b0, add_w[W]};

`ifdef CS_RESOLVE_REDUCE_EN
      m_d      = m_q;
      d_d      = d_q;
      borrow_d = borrow_q;
      pass_d   = pass_q;

      // Subtract the current digit, then fold the top two bits in for the whole-pass borrow.
      sub_w        = {1'b0, s_q[dig_lo +: W]} - {1'b0, m_q[dig_lo +: W]} - {{W{1'b0}}, borrow_q};
      d_full       = d_q;
      d_full[dig_lo +: W] = sub_w[W-1:0];
      top_diff     = s_q[N+1:N] - {1'b0, sub_w[W]};
      final_borrow = sub_w[W] & (s_q[N+1:N] == 2'b00);
`endif

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               p_d     = p;
               q_d     = q;
               s_d     = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               carry_d = 1'b0;
`ifdef CS_RESOLVE_REDUCE_EN
               m_d      = m;
               borrow_d = 1'b0;
               pass_d   = 2'd0;
`endif
               state_d = S_ADD;
            end
         end

         S_ADD: begin
            s_d[dig_lo +: W] = add_w[W-1:0];
            carry_d          = add_w[W];
            if (cnt_q == LAST) begin
               s_d[N+1:N] = top_sum;
               carry_d    = 1'b0;
               cnt_d      = '0;
`ifdef CS_RESOLVE_REDUCE_EN
               state_d    = S_SUB;
`else
               ovf_d      = |top_sum;
               state_d    = S_HOLD;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

`ifdef CS_RESOLVE_REDUCE_EN
         S_SUB: begin
            d_d      = d_full;
            borrow_d = sub_w[W];
            if (cnt_q == LAST) begin
               cnt_d    = '0;
               borrow_d = 1'b0;
               if (final_borrow) begin
                  // s < m: already reduced, keep s.
                  state_d = S_HOLD;
               end else if (pass_q == 2'd3) begin
                  // 4th pass is compare-only: still >= m means not fully reduced.
                  ovf_d   = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  s_d    = {top_diff, d_full};
                  pass_d = pass_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif

         S_HOLD: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low clear.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         p_q      <= '0;
         q_q      <= '0;
         s_q      <= '0;
         ovf_q    <= 1'b0;
`ifdef CS_RESOLVE_REDUCE_EN
         m_q      <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         pass_q   <= 2'd0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         p_q      <= p_d;
         q_q      <= q_d;
         s_q      <= s_d;
         ovf_q    <= ovf_d;
`ifdef CS_RESOLVE_REDUCE_EN
         m_q      <= m_d;
         d_q      <= d_d;
         borrow_q <= borrow_d;
         pass_q   <= pass_d;
`endif
      end
   end

endmodule

// File: tb/tb_cs_resolve.sv
// Testbench for cs_resolve, with N=8 and W=4 (C=2).
// Expected values follow whichever build is compiled:
//   - CS_RESOLVE_REDUCE_EN defined: the reduced result;
//   - macro undefined: the raw sum.
module tb_cs_resolve;

   localparam int N = 8;
   localparam int W = 4;

`ifdef CS_RESOLVE_REDUCE_EN
   localparam bit RED = 1'b1;
`else
   localparam bit RED = 1'b0;
`endif

   logic         clock;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [N:0]   p;
   logic [N:0]   q;
   logic [N-1:0] m;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] z;
   logic         ovf;
   logic [1:0]   dbg_state;

   cs_resolve #(.N(N), .W(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p         (p),
      .q         (q),
      .m         (m),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .ovf       (ovf),
      .dbg_state (dbg_state)
   );

   // Clock and reset.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   logic [N-1:0] exp_q[$];

   typedef struct {
      logic [N:0]   p;
      logic [N:0]   q;
      logic [N-1:0] m;
      logic [N-1:0] z_red;
      logic         ovf_red;
      int           lat_red;
      logic [N-1:0] z_raw;
      logic         ovf_raw;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drive one operand, measure the latency to out_valid, and check the result.
   // Optionally stall in HOLD for 'hold' cycles while pushing a competing in_valid.
   task automatic run_op(input string name, input logic [N:0] pi, input logic [N:0] qi,
                         input logic [N-1:0] mi, input logic [N-1:0] ez, input logic eo,
                         input int el, input int hold);
      int cnt;
      logic [N-1:0] sz;
      check({name, " in_ready idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      p = pi;
      q = qi;
      m = mi;
      exp_q.push_back(ez);
      step();
      // Inputs change after the accept edge; the captured copy must be used.
      in_valid = 1'b0;
      p = ~pi;
      q = ~qi;
      m = ~mi;
      check({name, " in_ready busy"}, 32'(in_ready), 32'd0);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!out_valid && cnt < 40);
      check({name, " latency"}, 32'(cnt), 32'(el));
      sz = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({name, " z"}, 32'(z), 32'(sz));
      check({name, " ovf"}, 32'(ovf), 32'(eo));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         p = 9'h055;
         q = 9'h0AA;
         step();
         check({name, " hold out_valid"}, 32'(out_valid), 32'd1);
         check({name, " hold z"}, 32'(z), 32'(sz));
         check({name, " hold ovf"}, 32'(ovf), 32'(eo));
         check({name, " hold in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({name, " release out_valid"}, 32'(out_valid), 32'd0);
      check({name, " release in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      int rst_wait;
      logic seen_valid;

      //          p       q       m      z_red  ovf  lat  z_raw  ovf_raw
      vecs[0] = '{9'h005, 9'h003, 8'hFB, 8'h08, 1'b0, 4,  8'h08, 1'b0};
      vecs[1] = '{9'h1FF, 9'h001, 8'hC8, 8'h70, 1'b0, 8,  8'h00, 1'b1};
      vecs[2] = '{9'h1FF, 9'h1FF, 8'h01, 8'hFB, 1'b1, 10, 8'hFE, 1'b1};
      vecs[3] = '{9'h0AB, 9'h044, 8'h00, 8'hEF, 1'b1, 10, 8'hEF, 1'b0};
      vecs[4] = '{9'h100, 9'h100, 8'h80, 8'h80, 1'b1, 10, 8'h00, 1'b1};
      vecs[5] = '{9'h0F0, 9'h00F, 8'hFF, 8'h00, 1'b0, 6,  8'hFF, 1'b0};
      vecs[6] = '{9'h123, 9'h0DC, 8'h64, 8'hD3, 1'b1, 10, 8'hFF, 1'b1};
      vecs[7] = '{9'h08F, 9'h071, 8'hA0, 8'h60, 1'b0, 6,  8'h00, 1'b1};
      vecs[8] = '{9'h000, 9'h000, 8'h05, 8'h00, 1'b0, 4,  8'h00, 1'b0};

      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      p = '0;
      q = '0;
      m = '0;
      step();
      step();
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset z", 32'(z), 32'd0);
      check("reset ovf", 32'(ovf), 32'd0);
      reset = 1'b1;
      step();

      // Table of directed operands.
      for (int i = 0; i < 9; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].p, vecs[i].q, vecs[i].m,
                RED ? vecs[i].z_red : vecs[i].z_raw,
                RED ? vecs[i].ovf_red : vecs[i].ovf_raw,
                RED ? vecs[i].lat_red : 2, 0);
      end

      // Long stall in HOLD with a competing in_valid, then release.
      run_op("hold5", vecs[2].p, vecs[2].q, vecs[2].m,
             RED ? vecs[2].z_red : vecs[2].z_raw,
             RED ? vecs[2].ovf_red : vecs[2].ovf_raw,
             RED ? vecs[2].lat_red : 2, 5);

      // Reset in the middle of an operation (2nd SUB pass, or mid-ADD without reduction).
      in_valid = 1'b1;
      p = vecs[1].p;
      q = vecs[1].q;
      m = vecs[1].m;
      step();
      in_valid = 1'b0;
      rst_wait = RED ? 5 : 1;
      for (int i = 0; i < rst_wait; i++) step();
      reset = 1'b0;
      step();
      check("midrst in_ready", 32'(in_ready), 32'd1);
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst z", 32'(z), 32'd0);
      check("midrst ovf", 32'(ovf), 32'd0);
      reset = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen_valid = 1'b1;
      end
      check("midrst no out_valid", 32'(seen_valid), 32'd0);
      run_op("after_rst", vecs[0].p, vecs[0].q, vecs[0].m,
             RED ? vecs[0].z_red : vecs[0].z_raw,
             RED ? vecs[0].ovf_red : vecs[0].ovf_raw,
             RED ? vecs[0].lat_red : 2, 0);
      check("exp_q drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
